// File: rtl/bayer_demosaic.sv
// 2x2 Bayer-to-RGB demosaic with a one-row inferred line buffer, runtime phase
// select, edge blanking and line-overflow flag. Define DEMOSAIC_GAIN_EN for per-channel gains.
module bayer_demosaic #(
  parameter int DATA_W   = 8,
  parameter int MAX_COLS = 2048,
  parameter int COL_W    = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        pattern,
  input  logic              in_vs,
  input  logic              in_hs,
  input  logic              in_de,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vs,
  output logic              out_hs,
  output logic              out_de,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic              line_ovf
`ifdef DEMOSAIC_GAIN_EN
  ,
  input  logic [11:0]       gain_r,
  input  logic [11:0]       gain_g,
  input  logic [11:0]       gain_b
`endif
);

`ifdef DEMOSAIC_GAIN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [COL_W-1:0] CNT_MAX = '1;
  localparam logic [COL_W-1:0] COL_LIM = COL_W'(MAX_COLS);

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } rgb_t;

  logic [COL_W-1:0]   col, row;
  logic               de_d;
  logic [1:0]         pat_q;
  logic               col_ovf;
  logic [2:0]         sync_in;
  logic [LAT:1][2:0]  vld_pipe;

  assign col_ovf = (col >= COL_LIM);
  assign sync_in = {in_vs, in_hs, in_de};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
    end else begin
      for (int i = LAT; i > 1; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[1] <= sync_in;
    end
  end

  assign {out_vs, out_hs, out_de} = vld_pipe[LAT];

  // Position counters; both saturate so a runaway row never wraps into valid addresses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col      <= '0;
      row      <= '0;
      de_d     <= 1'b0;
      pat_q    <= 2'd0;
      line_ovf <= 1'b0;
    end else begin
      de_d <= in_de;
      if (!in_de)               col <= '0;
      else if (col != CNT_MAX)  col <= col + 1'b1;
      if (in_vs)                                      row <= '0;
      else if (de_d && !in_de && row != CNT_MAX)      row <= row + 1'b1;
      if (in_vs) pat_q <= pattern;
      if (in_vs)                   line_ovf <= 1'b0;
      else if (in_de && col_ovf)   line_ovf <= 1'b1;
    end
  end

  // Line buffer: read returns the previous row at this column, then is overwritten.
  logic [DATA_W-1:0] line_ram [MAX_COLS];
  logic [DATA_W-1:0] ram_q;
  logic [AW-1:0]     ram_addr;

  assign ram_addr = col[AW-1:0];

  always_ff @(posedge clk) begin
    ram_q <= line_ram[ram_addr];
    if (in_de && !col_ovf) line_ram[ram_addr] <= in_data;
  end

  logic [DATA_W-1:0] p00, p10, p11;
  logic              s1_de, s1_blank;
  logic [1:0]        s1_phase;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p00      <= '0;
      p10      <= '0;
      p11      <= '0;
      s1_de    <= 1'b0;
      s1_blank <= 1'b1;
      s1_phase <= 2'd0;
    end else begin
      p11      <= in_data;
      p10      <= p11;
      p00      <= ram_q;
      s1_de    <= in_de;
      s1_blank <= (row == '0) || (col == '0) || col_ovf;
      s1_phase <= pat_q ^ {~row[0], ~col[0]};
    end
  end

  logic [DATA_W:0] g_x, g_y;
  rgb_t            dm, out_rgb;

  always_comb begin
    g_x = {1'b0, ram_q} + {1'b0, p10};
    g_y = {1'b0, p00} + {1'b0, p11};
    dm  = '0;
    case (s1_phase)
      2'd0:    begin dm.r = p00;   dm.g = DATA_W'(g_x >> 1); dm.b = p11;   end
      2'd1:    begin dm.r = ram_q; dm.g = DATA_W'(g_y >> 1); dm.b = p10;   end
      2'd2:    begin dm.r = p10;   dm.g = DATA_W'(g_y >> 1); dm.b = ram_q; end
      default: begin dm.r = p11;   dm.g = DATA_W'(g_x >> 1); dm.b = p00;   end
    endcase
    if (!s1_de || s1_blank) dm = '0;
  end

`ifdef DEMOSAIC_GAIN_EN
  // 4.8 fixed-point gain: truncate the fraction, then clip to full scale.
  function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] ch,
                                                   input logic [11:0] g);
    logic [DATA_W+11:0] prod;
    prod = (DATA_W+12)'(ch) * (DATA_W+12)'(g);
    if (|prod[DATA_W+11:DATA_W+8]) return '1;
    return prod[DATA_W+7:8];
  endfunction

  logic [11:0] gr_q, gg_q, gb_q;
  rgb_t        dm_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gr_q    <= 12'h100;
      gg_q    <= 12'h100;
      gb_q    <= 12'h100;
      dm_q    <= '0;
      out_rgb <= '0;
    end else begin
      if (in_vs) begin
        gr_q <= gain_r;
        gg_q <= gain_g;
        gb_q <= gain_b;
      end
      dm_q      <= dm;
      out_rgb.r <= apply_gain(dm_q.r, gr_q);
      out_rgb.g <= apply_gain(dm_q.g, gg_q);
      out_rgb.b <= apply_gain(dm_q.b, gb_q);
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_rgb <= '0;
    else         out_rgb <= dm;
  end
`endif

  assign out_r = out_rgb.r;
  assign out_g = out_rgb.g;
  assign out_b = out_rgb.b;

endmodule

// File: doc/bayer_demosaic.md
# bayer_demosaic

Parametrised 2x2 Bayer-to-RGB demosaic for the HDMI video path. It sits between the MIPI raw-pixel stream and the HDMI encoder, and converts one raw sample per clock into one RGB pixel per clock. It buffers the previous row in an inferred line RAM, which replaces the vendor FIFO. It adds configurable data width, maximum line length, a runtime Bayer phase select, defined edge handling and line-overflow detection.

## Interface
- DATA_W, 8: raw and per-channel RGB sample width.
- MAX_COLS, 2048: line-buffer depth, the maximum active pixels per row.
- COL_W, 12: column/row counter width; must be at least clog2(MAX_COLS)+1.
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous, active-low reset.
- pattern  in  2  colour of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR. Sampled while in_vs=1.
- in_vs / in_hs / in_de  in  1 each  input syncs; in_vs is active-high and level-sensitive.
- in_data  in  DATA_W  raw sample, valid when in_de=1.
- out_vs / out_hs / out_de  out  1 each  input syncs delayed by LAT cycles.
- out_r / out_g / out_b  out  DATA_W each  RGB pixel; zero when out_de=0.
- line_ovf  out  1  sticky flag: a row exceeded MAX_COLS; cleared while in_vs=1.
- gain_r / gain_g / gain_b  in  12 each  unsigned 4.8 gains (1.0 = 12'h100). Present only with DEMOSAIC_GAIN_EN. Sampled while in_vs=1.

## Operation
- Reset: all outputs are 0, counters are 0, the latched pattern is 0, and the latched gains are 12'h100.
- col: increments on each in_de=1 cycle and is forced to 0 whenever in_de=0. A pixel's column is the col value before the increment.
- row: increments on each falling edge of in_de and is held at 0 while in_vs=1.
- Line buffer: a single-port RAM, depth MAX_COLS, with read-before-write at address col. The read returns row r-1; the current sample is written in the same cycle. Read latency is 1 cycle; the current sample is registered once to align with the read.
- Window for pixel (r,c):
  - P00 = prev row, col c-1
  - P01 = prev row, col c
  - P10 = cur row, col c-1
  - P11 = cur row, col c
- Phase = pattern XOR {~r[0], ~c[0]} gives the Bayer order of P00.
  - RGGB: R=P00, B=P11, G=(P01+P10)>>1
  - GRBG: R=P01, B=P10, G=(P00+P11)>>1
  - GBRG: R=P10, B=P01, G=(P00+P11)>>1
  - BGGR: R=P11, B=P00, G=(P01+P10)>>1
- G sum is DATA_W+1 bits wide and truncated by the shift; it never overflows.
- Edges: pixels with r=0 or c=0 output R=G=B=0 with out_de=1.
- Overflow: when col ≥ MAX_COLS, RAM writes are suppressed, the pixel outputs black, and line_ovf is set. line_ovf holds until the next in_vs=1. Counters saturate at their maximum.
- pattern and gains are captured continuously while in_vs=1 and frozen when in_vs=0. A change mid-frame has no effect until the next vsync.
- Reset asserted mid-frame clears everything immediately. After reset release, output is valid from the next in_vs onward; before then, row counts from 0.

## Timing
- LAT = 2 without DEMOSAIC_GAIN_EN, 3 with it.
- Output pixel k appears LAT cycles after in_data k.
- out_vs, out_hs and out_de equal the inputs delayed by exactly LAT cycles, including during reset release.
- Throughput is one pixel per clock with no stalls and no backpressure.
- Back-to-back rows with a 1-cycle in_de gap are supported.

## Configuration
- DEMOSAIC_GAIN_EN defined:
  - gain_r, gain_g and gain_b ports exist.
  - After demosaic, each channel = min((ch × gain) >> 8, 2^DATA_W−1), i.e. truncated, then saturated.
  - One extra register stage; LAT=3.
- Not defined: the ports are absent, there is no multiplier, and LAT=2.

## Test plan
- Reset: hold resetn=0 with random inputs → all outputs 0, line_ovf=0. Release → out_* syncs follow the inputs at LAT.
- Mosaic decode: 4x4 RGGB frame with R=200, G=100/120, B=50, DATA_W=8 → row 0 and col 0 outputs black. Every other pixel gives R=200, G=110, B=50, out_de aligned at LAT.
- Pattern select: same frame data with pattern=3 (BGGR), pattern changed at vsync → R and B swap (R=50, B=200, G=110). A pattern change mid-frame is ignored until the next vsync.
- G rounding: G samples 255 and 254 → G=254, no wrap.
- Overflow: MAX_COLS=8 with a 10-pixel row → pixels 8 and 9 are black and line_ovf=1. The next row's window is still correct. line_ovf clears at in_vs.
- Gain (DEMOSAIC_GAIN_EN): gain_r=12'h200, R=200 → out_r=255 (saturated). gain_b=12'h080, B=50 → out_b=25. LAT=3.
